// File: rtl/rv32_mem_arbiter.sv
// Fetch/data arbiter onto one memory port: grant 1 cycle after request, rvalid 1 cycle after mem_ready_i, abort after WAIT_MAX stalled cycles.
// Requesters hold req until gnt; optional round-robin with RV32_ARB_RR_EN (default: data always beats fetch).
`timescale 1ns/1ps
module rv32_mem_arbiter #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_data_i,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     state, state_nxt;
  logic       armed;
  logic [7:0] wait_cnt;
  logic       pick_d;
  logic       start, done, abort;

`ifdef RV32_ARB_RR_EN
  logic last_d;
  // On a tie the requester that was not served last wins; singles go straight through.
  assign pick_d = d_req_i && (!if_req_i || !last_d);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_d <= 1'b0;
    end else if (start) begin
      last_d <= pick_d;
    end
  end
`else
  assign pick_d = d_req_i;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (armed && (if_req_i || d_req_i)) begin
          start     = 1'b1;
          state_nxt = pick_d ? D_ACC : IF_ACC;
        end
      end
      IF_ACC, D_ACC: begin
        // Ready on the final allowed cycle still completes normally.
        if (mem_ready_i) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      armed       <= 1'b0;
      wait_cnt    <= '0;
      if_gnt_o    <= 1'b0;
      d_gnt_o     <= 1'b0;
      if_rvalid_o <= 1'b0;
      d_rvalid_o  <= 1'b0;
      err_o       <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      if_rdata_o  <= '0;
      d_rdata_o   <= '0;
    end else begin
      // Arbitration is held off for one edge after reset release.
      armed       <= 1'b1;
      if_gnt_o    <= start && !pick_d;
      d_gnt_o     <= start && pick_d;
      if_rvalid_o <= done && (state == IF_ACC);
      d_rvalid_o  <= done && (state == D_ACC);
      err_o       <= abort;

      if (start) begin
        mem_req_o  <= 1'b1;
        mem_we_o   <= pick_d && d_we_i;
        mem_addr_o <= pick_d ? d_addr_i : if_addr_i;
        mem_data_o <= pick_d ? d_wdata_i : 32'h0;
        wait_cnt   <= '0;
      end else if (done || abort) begin
        mem_req_o <= 1'b0;
      end else if (state != IDLE) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (done && (state == IF_ACC)) begin
        if_rdata_o <= mem_data_i;
      end
      // Stores are acknowledged but leave the load data untouched.
      if (done && (state == D_ACC) && !mem_we_o) begin
        d_rdata_o <= mem_data_i;
      end
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Self-checking bench for rv32_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_rv32_mem_arbiter;

  localparam int WAIT_MAX = 15;
`ifdef RV32_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [31:0] d_addr_i = '0;
  logic [31:0] d_wdata_i = '0;
  logic        d_gnt_o, d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_data_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_data_i = '0;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  rv32_mem_arbiter #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ready_i(mem_ready_i), .mem_data_i(mem_data_i),
    .err_o(err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] exp_if_rdata, exp_d_rdata;
  bit          model_last_d;
  bit          pend_if, pend_d;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h1000 + (32'($urandom_range(0, 15)) << 2);
  endfunction

  task automatic do_reset();
    rst_i = 1'b0;
    if_req_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0;
    if_addr_i = '0; d_addr_i = '0; d_wdata_i = '0;
    mem_ready_i = 1'b0; mem_data_i = '0;
    pend_if = 1'b0; pend_d = 1'b0; model_last_d = 1'b0;
    exp_if_rdata = '0; exp_d_rdata = '0;
    tick(); tick();
    rst_i = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset();
    bit seen;
    rst_i = 1'b0;
    d_req_i = 1'b1; d_addr_i = 32'h44; d_we_i = 1'b0; mem_ready_i = 1'b1; mem_data_i = 32'hFFFF_FFFF;
    tick(); tick();
    n_checks++;
    if ({if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_req_o, mem_we_o, err_o} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000000", {if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_req_o, mem_we_o, err_o});
    end
    n_checks++;
    if ({mem_addr_o, mem_data_o, if_rdata_o, d_rdata_o} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h want all zero", mem_addr_o, mem_data_o, if_rdata_o, d_rdata_o);
    end
    mem_ready_i = 1'b0;
    rst_i = 1'b1;
    tick();
    n_checks++;
    if (d_gnt_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_edge_gnt: got %b want 0", d_gnt_o);
    end
    seen = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin
      tick();
      seen = d_gnt_o;
    end
    n_checks++;
    if (!seen || mem_addr_o !== 32'h44) begin
      n_fail++;
      $display("FAIL reset_late_gnt: got gnt=%b addr=%h want gnt=1 addr=00000044", seen, mem_addr_o);
    end
    d_req_i = 1'b0; mem_ready_i = 1'b1; mem_data_i = 32'hCAFE_0001;
    tick();
    mem_ready_i = 1'b0;
    n_checks++;
    if ({d_rvalid_o, d_rdata_o} !== {1'b1, 32'hCAFE_0001}) begin
      n_fail++;
      $display("FAIL reset_first_load: got rvalid=%b rdata=%h want 1 cafe0001", d_rvalid_o, d_rdata_o);
    end
  endtask

  task automatic test_fetch();
    do_reset();
    if_req_i = 1'b1; if_addr_i = 32'h100;
    tick();
    n_checks++;
    if ({if_gnt_o, d_gnt_o, mem_req_o, mem_we_o, mem_addr_o} !== {4'b1010, 32'h100}) begin
      n_fail++;
      $display("FAIL fetch_grant: got gnt=%b dgnt=%b req=%b we=%b addr=%h want 1 0 1 0 00000100",
               if_gnt_o, d_gnt_o, mem_req_o, mem_we_o, mem_addr_o);
    end
    if_req_i = 1'b0; if_addr_i = 32'hBAD0_0000;
    tick();
    n_checks++;
    if ({if_gnt_o, mem_req_o, if_rvalid_o, mem_addr_o} !== {3'b010, 32'h100}) begin
      n_fail++;
      $display("FAIL fetch_wait: got gnt=%b req=%b rvalid=%b addr=%h want 0 1 0 00000100",
               if_gnt_o, mem_req_o, if_rvalid_o, mem_addr_o);
    end
    tick();
    mem_ready_i = 1'b1; mem_data_i = 32'h0050_0093;
    tick();
    mem_ready_i = 1'b0; mem_data_i = 32'h0;
    n_checks++;
    if ({if_rvalid_o, mem_req_o, if_rdata_o} !== {2'b10, 32'h0050_0093}) begin
      n_fail++;
      $display("FAIL fetch_data: got rvalid=%b req=%b rdata=%h want 1 0 00500093", if_rvalid_o, mem_req_o, if_rdata_o);
    end
    tick();
    n_checks++;
    if ({if_rvalid_o, if_rdata_o} !== {1'b0, 32'h0050_0093}) begin
      n_fail++;
      $display("FAIL fetch_hold: got rvalid=%b rdata=%h want 0 00500093", if_rvalid_o, if_rdata_o);
    end
  endtask

  task automatic test_store();
    do_reset();
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h40; d_wdata_i = 32'hDEAD_BEEF;
    tick();
    n_checks++;
    if ({d_gnt_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o} !== {3'b111, 32'h40, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL store_grant: got gnt=%b req=%b we=%b addr=%h data=%h want 1 1 1 00000040 deadbeef",
               d_gnt_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o);
    end
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = 32'h0; d_wdata_i = 32'h0;
    mem_ready_i = 1'b1; mem_data_i = 32'h1234_5678;
    tick();
    mem_ready_i = 1'b0;
    n_checks++;
    if ({d_rvalid_o, err_o, mem_req_o, d_rdata_o} !== {3'b100, 32'h0}) begin
      n_fail++;
      $display("FAIL store_ack: got rvalid=%b err=%b req=%b rdata=%h want 1 0 0 00000000",
               d_rvalid_o, err_o, mem_req_o, d_rdata_o);
    end
  endtask

  task automatic test_priority();
    bit exp_d;
    do_reset();
    if_req_i = 1'b1; if_addr_i = 32'h200; d_req_i = 1'b1; d_addr_i = 32'h300; d_we_i = 1'b0;
    for (int t = 0; t < 4; t++) begin
      exp_d = RR ? (t % 2 == 0) : 1'b1;
      tick();
      n_checks++;
      if ({d_gnt_o, if_gnt_o} !== {exp_d, !exp_d}) begin
        n_fail++;
        $display("FAIL arb_order[%0d]: got d_gnt/if_gnt=%b%b want %b%b", t, d_gnt_o, if_gnt_o, exp_d, !exp_d);
      end
      mem_ready_i = 1'b1; mem_data_i = 32'h1111_0000 + 32'(t);
      tick();
      mem_ready_i = 1'b0;
      n_checks++;
      if ({d_rvalid_o, if_rvalid_o} !== {exp_d, !exp_d}) begin
        n_fail++;
        $display("FAIL arb_rvalid[%0d]: got d/if=%b%b want %b%b", t, d_rvalid_o, if_rvalid_o, exp_d, !exp_d);
      end
    end
    if_req_i = 1'b0; d_req_i = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h80;
    tick();
    n_checks++;
    if (d_gnt_o !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_gnt: got %b want 1", d_gnt_o);
    end
    d_req_i = 1'b0; d_addr_i = 32'hFFFF_FFF0;
    if_req_i = 1'b1; if_addr_i = 32'h500;
    for (int k = 1; k < WAIT_MAX; k++) begin
      tick();
      n_checks++;
      if ({mem_req_o, mem_addr_o, err_o, d_rvalid_o, if_gnt_o} !== {1'b1, 32'h80, 3'b000}) begin
        n_fail++;
        $display("FAIL timeout_hold[%0d]: got req=%b addr=%h err=%b rvalid=%b ignt=%b want 1 00000080 0 0 0",
                 k, mem_req_o, mem_addr_o, err_o, d_rvalid_o, if_gnt_o);
      end
    end
    tick();
    n_checks++;
    if ({err_o, d_rvalid_o, mem_req_o, d_rdata_o} !== {3'b100, 32'h0}) begin
      n_fail++;
      $display("FAIL timeout_err: got err=%b rvalid=%b req=%b rdata=%h want 1 0 0 00000000",
               err_o, d_rvalid_o, mem_req_o, d_rdata_o);
    end
    tick();
    n_checks++;
    if ({if_gnt_o, err_o, mem_addr_o} !== {2'b10, 32'h500}) begin
      n_fail++;
      $display("FAIL timeout_next_gnt: got gnt=%b err=%b addr=%h want 1 0 00000500", if_gnt_o, err_o, mem_addr_o);
    end
    if_req_i = 1'b0; mem_ready_i = 1'b1; mem_data_i = 32'h0000_0013;
    tick();
    mem_ready_i = 1'b0;
    n_checks++;
    if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'h0000_0013}) begin
      n_fail++;
      $display("FAIL timeout_next_data: got rvalid=%b rdata=%h want 1 00000013", if_rvalid_o, if_rdata_o);
    end
  endtask

  task automatic test_ready_wins();
    do_reset();
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h84;
    tick();
    d_req_i = 1'b0;
    repeat (WAIT_MAX - 1) tick();
    mem_ready_i = 1'b1; mem_data_i = 32'h7777_0001;
    tick();
    mem_ready_i = 1'b0;
    n_checks++;
    if ({d_rvalid_o, err_o, d_rdata_o} !== {2'b10, 32'h7777_0001}) begin
      n_fail++;
      $display("FAIL ready_wins: got rvalid=%b err=%b rdata=%h want 1 0 77770001", d_rvalid_o, err_o, d_rdata_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h20;
    tick();
    d_req_i = 1'b0;
    tick();
    rst_i = 1'b0; mem_ready_i = 1'b1; mem_data_i = 32'hFFFF_0000;
    #1;
    n_checks++;
    if ({d_gnt_o, d_rvalid_o, mem_req_o, mem_we_o, err_o, mem_addr_o, d_rdata_o} !== 69'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got gnt=%b rvalid=%b req=%b we=%b err=%b addr=%h rdata=%h want all zero",
               d_gnt_o, d_rvalid_o, mem_req_o, mem_we_o, err_o, mem_addr_o, d_rdata_o);
    end
    tick();
    n_checks++;
    if ({d_rvalid_o, err_o, mem_req_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: got rvalid=%b err=%b req=%b want 000", d_rvalid_o, err_o, mem_req_o);
    end
    mem_ready_i = 1'b0;
    rst_i = 1'b1;
    tick(); tick();
    d_req_i = 1'b1; d_addr_i = 32'h24;
    tick();
    n_checks++;
    if ({d_gnt_o, mem_addr_o} !== {1'b1, 32'h24}) begin
      n_fail++;
      $display("FAIL reset_mid_regrant: got gnt=%b addr=%h want 1 00000024", d_gnt_o, mem_addr_o);
    end
    d_req_i = 1'b0; mem_ready_i = 1'b1; mem_data_i = 32'h0BAD_F00D;
    tick();
    mem_ready_i = 1'b0;
    n_checks++;
    if ({d_rvalid_o, d_rdata_o} !== {1'b1, 32'h0BAD_F00D}) begin
      n_fail++;
      $display("FAIL reset_mid_load: got rvalid=%b rdata=%h want 1 0badf00d", d_rvalid_o, d_rdata_o);
    end
  endtask

  // One arbitrated transaction; called in the cycle the pending requests are visible.
  task automatic run_txn(input int lat);
    bit          win_d, we, fin;
    logic [31:0] a, wd, rd;
    win_d = pend_d && (!pend_if || !RR || !model_last_d);
    a     = win_d ? d_addr_i : if_addr_i;
    we    = win_d && d_we_i;
    wd    = d_wdata_i;
    rd    = mem_read(a);
    tick();
    n_checks++;
    if ({if_gnt_o, d_gnt_o, mem_req_o, mem_we_o, mem_addr_o} !== {!win_d, win_d, 1'b1, we, a}) begin
      n_fail++;
      $display("FAIL rnd_grant: got ig=%b dg=%b req=%b we=%b addr=%h want %b %b 1 %b %h",
               if_gnt_o, d_gnt_o, mem_req_o, mem_we_o, mem_addr_o, !win_d, win_d, we, a);
    end
    if (we) begin
      n_checks++;
      if (mem_data_o !== wd) begin
        n_fail++;
        $display("FAIL rnd_wdata: got %h want %h", mem_data_o, wd);
      end
    end
    model_last_d = win_d;
    if (win_d) begin
      pend_d = 1'b0; d_req_i = 1'b0;
      d_addr_i = $urandom; d_wdata_i = $urandom; d_we_i = 1'($urandom_range(0, 1));
    end else begin
      pend_if = 1'b0; if_req_i = 1'b0; if_addr_i = $urandom;
    end
    for (int k = 0; k < WAIT_MAX; k++) begin
      mem_ready_i = (k == lat);
      mem_data_i  = (k == lat) ? rd : $urandom;
      tick();
      mem_ready_i = 1'b0;
      if (k == lat || k == WAIT_MAX - 1) break;
      n_checks++;
      if ({mem_req_o, mem_addr_o, if_rvalid_o | d_rvalid_o, err_o, if_gnt_o | d_gnt_o} !== {1'b1, a, 3'b000}) begin
        n_fail++;
        $display("FAIL rnd_acc_hold: got req=%b addr=%h rv=%b err=%b gnt=%b want 1 %h 0 0 0",
                 mem_req_o, mem_addr_o, if_rvalid_o | d_rvalid_o, err_o, if_gnt_o | d_gnt_o, a);
      end
    end
    fin = (lat < WAIT_MAX);
    if (fin && !win_d) exp_if_rdata = rd;
    if (fin && win_d && !we) exp_d_rdata = rd;
    if (fin && we) mem_model[a] = wd;
    n_checks++;
    if ({if_rvalid_o, d_rvalid_o, err_o, mem_req_o} !== {fin && !win_d, fin && win_d, !fin, 1'b0}) begin
      n_fail++;
      $display("FAIL rnd_end: got irv=%b drv=%b err=%b req=%b want %b %b %b 0",
               if_rvalid_o, d_rvalid_o, err_o, mem_req_o, fin && !win_d, fin && win_d, !fin);
    end
    n_checks++;
    if ({if_rdata_o, d_rdata_o} !== {exp_if_rdata, exp_d_rdata}) begin
      n_fail++;
      $display("FAIL rnd_rdata: got if=%h d=%h want if=%h d=%h", if_rdata_o, d_rdata_o, exp_if_rdata, exp_d_rdata);
    end
  endtask

  task automatic test_random();
    int r, lat;
    do_reset();
    for (int it = 0; it < 150; it++) begin
      if (!pend_if && $urandom_range(0, 2) != 0) begin
        pend_if = 1'b1; if_req_i = 1'b1; if_addr_i = rand_addr();
      end
      if (!pend_d && $urandom_range(0, 2) != 0) begin
        pend_d = 1'b1; d_req_i = 1'b1; d_addr_i = rand_addr();
        d_we_i = 1'($urandom_range(0, 1)); d_wdata_i = $urandom;
      end
      if (!pend_if && !pend_d) begin
        // Stray ready while idle must be ignored.
        mem_ready_i = 1'($urandom_range(0, 1)); mem_data_i = $urandom;
        tick();
        mem_ready_i = 1'b0;
        n_checks++;
        if ({if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, err_o, mem_req_o} !== 6'b0) begin
          n_fail++;
          $display("FAIL rnd_idle: got %b want 000000", {if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, err_o, mem_req_o});
        end
      end else begin
        r = $urandom_range(0, 9);
        if (r < 6)       lat = $urandom_range(0, 3);
        else if (r < 8)  lat = WAIT_MAX - 1;
        else if (r == 8) lat = WAIT_MAX;
        else             lat = 30;
        run_txn(lat);
      end
    end
    if_req_i = 1'b0; d_req_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_priority();
    test_timeout();
    test_ready_wins();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_mem_arbiter.md
RV32_MEM_ARBITER -- requirements
Module: rv32_mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15, max cycles a granted access waits for mem_ready_i before abort (range 1..255).
REQ-002 SHALL have port clk_i  input  1  single clock; all state changes on posedge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port if_req_i  input  1  instruction-fetch request, held until if_gnt_o.
REQ-005 SHALL have port if_addr_i  input  32  fetch address.
REQ-006 SHALL have ports if_gnt_o, if_rvalid_o  output  1 each  fetch grant pulse, fetch data-valid pulse.
REQ-007 SHALL have port if_rdata_o  output  32  fetched instruction.
REQ-008 SHALL have ports d_req_i, d_we_i  input  1 each  data request, write enable (1=STORE, 0=LOAD).
REQ-009 SHALL have ports d_addr_i, d_wdata_i  input  32 each  data address, store data.
REQ-010 SHALL have ports d_gnt_o, d_rvalid_o  output  1 each  data grant pulse, data completion pulse (LOAD and STORE).
REQ-011 SHALL have port d_rdata_o  output  32  load data.
REQ-012 SHALL have ports mem_req_o, mem_we_o  output  1 each  shared memory request, write enable.
REQ-013 SHALL have ports mem_addr_o, mem_data_o  output  32 each  memory address, write data.
REQ-014 SHALL have ports mem_ready_i  input  1, mem_data_i  input  32  memory completion, read data.
REQ-015 SHALL have port err_o  output  1  timeout abort pulse.

Function
REQ-016 SHALL implement FSM states IDLE, IF_ACC, D_ACC.
REQ-017 IDLE: at posedge with a request pending, SHALL select a requester (REQ-030/031), enter IF_ACC or D_ACC; else stay IDLE.
REQ-018 On entering an ACC state, SHALL latch address, we and wdata into mem_addr_o/mem_we_o/mem_data_o and assert mem_req_o the same cycle; requester inputs ignored afterwards.
REQ-019 SHALL pulse the winner's gnt_o for exactly the first ACC cycle; loser gets no grant and its request stays pending.
REQ-020 mem_req_o and memory outputs SHALL stay constant throughout an ACC state.
REQ-021 On posedge with mem_ready_i=1 in ACC: SHALL register mem_data_i into the owner's rdata_o, pulse owner's rvalid_o one cycle, deassert mem_req_o, return to IDLE.
REQ-022 Minimum transaction: request sampled cycle N, grant+mem_req_o cycle N+1, rvalid cycle N+2 if mem_ready_i=1 in N+1; back-to-back grants SHALL be separated by one IDLE cycle.
REQ-023 d_rdata_o for a STORE SHALL be unchanged; d_rvalid_o SHALL still pulse as acknowledge.
REQ-024 A wait counter (8 bit) SHALL count ACC cycles without mem_ready_i; at count WAIT_MAX, SHALL deassert mem_req_o, pulse err_o one cycle, issue no rvalid_o, return to IDLE.
REQ-025 mem_ready_i while IDLE SHALL be ignored.
REQ-026 mem_ready_i and timeout on the same edge: ready SHALL win, no err_o.
REQ-027 rdata_o SHALL hold last value between accesses.

Reset
REQ-028 rst_i low SHALL immediately force IDLE, all outputs 0 (rdata_o 0, mem_addr_o 0), wait counter 0, priority state to "data", including mid-transaction; the aborted access produces no rvalid_o or err_o.
REQ-029 After rst_i deasserts, first grant SHALL occur no earlier than the second posedge.

Configuration
REQ-030 Without RV32_ARB_RR_EN: fixed priority, data over fetch whenever both pending.
REQ-031 With RV32_ARB_RR_EN defined: simultaneous requests SHALL be granted to the requester NOT served last (reset last-served = fetch, so data wins first); single requests granted immediately regardless.

Verification
REQ-032 Fetch only, if_addr_i=0x100, mem_ready_i=1 after 2 ACC cycles, mem_data_i=0x00500093 -> if_gnt_o at N+1, if_rvalid_o at N+4, if_rdata_o=0x00500093.
REQ-033 STORE d_addr_i=0x40, d_wdata_i=0xDEADBEEF, ready immediate -> mem_we_o=1, mem_addr_o=0x40, mem_data_o=0xDEADBEEF, d_rvalid_o at N+2, d_rdata_o unchanged.
REQ-034 if_req_i and d_req_i held high 4 transactions -> without macro D,D,D,D (fetch starves); with RV32_ARB_RR_EN D,F,D,F.
REQ-035 Grant LOAD, mem_ready_i never asserted, WAIT_MAX=15 -> err_o pulse after 15 ACC cycles, no d_rvalid_o, next pending request granted after one IDLE cycle.
REQ-036 rst_i low during D_ACC then mem_ready_i=1 -> all outputs 0 at once, no d_rvalid_o; after release fresh requests served normally.
